// File: rtl/seg7_pkg.sv
// Shared seven-segment types and constants: segment byte, dark value, hex glyph table.
package seg7_pkg;

    typedef logic [7:0] seg_t;

    // Active-high "all segments dark" value, before output polarity is applied.
    localparam seg_t SEG_OFF = 8'h00;

    // Glyphs {g,f,e,d,c,b,a} for 0..F; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_scan_nch_if.sv
// Load-side bus and display pins of the N-digit scanner, with master/slave views.
interface seg7_scan_nch_if #(
    parameter int unsigned DIGITS = 8
);
    import seg7_pkg::*;

    logic                  we;
    logic                  raw_mode_in;
    logic [4*DIGITS-1:0]   hex_in;
    logic [8*DIGITS-1:0]   raw_in;
    logic [DIGITS-1:0]     point_in;
    logic [DIGITS-1:0]     blank_in;
    logic [DIGITS-1:0]     blink_in;
    logic [DIGITS-1:0]     an_o;
    seg_t                  seg_o;
    logic                  frame_o;

    modport master (
        output we, raw_mode_in, hex_in, raw_in, point_in, blank_in, blink_in,
        input  an_o, seg_o, frame_o
    );

    modport slave (
        input  we, raw_mode_in, hex_in, raw_in, point_in, blank_in, blink_in,
        output an_o, seg_o, frame_o
    );

endinterface

// File: rtl/seg7_hex_dec.sv
// Combinational nibble to seven-segment glyph lookup (active-high, no dp).
module seg7_hex_dec (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o_c
);
    import seg7_pkg::*;

    assign seg_o_c = HEX_SEG[nib_i];

endmodule

// File: rtl/seg7_scan_nch.sv
// Multiplexed N-digit seven-segment scanner with double-buffered, frame-aligned updates,
// per-digit blank/blink and raw-segment mode.
module seg7_scan_nch #(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned SCAN_DIV   = 17,
    parameter int unsigned BLINK_DIV  = 24,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic            clk,
    input  logic            rstn,
    seg7_scan_nch_if.slave  bus
);
    import seg7_pkg::*;

    localparam int unsigned     IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW != 0}};
    localparam seg_t            SEG_IDLE = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

    typedef struct packed {
        logic                raw_mode;
        logic [4*DIGITS-1:0] hex;
        logic [8*DIGITS-1:0] raw;
        logic [DIGITS-1:0]   point;
        logic [DIGITS-1:0]   blank;
        logic [DIGITS-1:0]   blink;
    } disp_t;

    logic [SCAN_DIV-1:0]  psc_q, psc_d;
    logic [BLINK_DIV-1:0] blink_q, blink_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 run_q, run_d;
    logic                 pending_q, pending_d;
    disp_t                shadow_q, shadow_d;
    disp_t                live_q, live_d;
    logic [DIGITS-1:0]    an_q, an_d;
    seg_t                 seg_q, seg_d;
    logic                 frame_q, frame_d;

    disp_t                in_now;
    logic                 tick;
    logic                 wrap;
    logic [3:0]           nib;
    logic [6:0]           dec_seg;
    logic [DIGITS-1:0]    an_hi;
    seg_t                 seg_hi;

    assign in_now = '{raw_mode: bus.raw_mode_in, hex: bus.hex_in, raw: bus.raw_in,
                      point: bus.point_in, blank: bus.blank_in, blink: bus.blink_in};

    // Timing, index and buffer update; run_q keeps the first tick on digit 0.
    always_comb begin
        tick      = &psc_q;
        wrap      = tick && run_q && (idx_q == IDX_LAST);
        psc_d     = psc_q + SCAN_DIV'(1);
        blink_d   = blink_q + BLINK_DIV'(1);
        run_d     = run_q | tick;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        live_d    = live_q;
        frame_d   = wrap;

        if (tick && run_q) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        if (bus.we) begin
            shadow_d  = in_now;
            pending_d = 1'b1;
        end
        // A load coinciding with the boundary bypasses the shadow so it is not a frame late.
        if (wrap) begin
            pending_d = 1'b0;
            if (pending_q || bus.we) begin
                live_d = bus.we ? in_now : shadow_q;
            end
        end
    end

    assign nib = live_d.hex[{idx_d, 2'b00} +: 4];

    seg7_hex_dec u_hex_dec (
        .nib_i   (nib),
        .seg_o_c (dec_seg)
    );

    // Pin values for the slot about to be shown; dark digits keep their anode.
    always_comb begin
        an_hi  = '0;
        seg_hi = SEG_OFF;
        if (run_d) begin
            an_hi = DIGITS'(1) << idx_d;
            if (live_d.blank[idx_d] || (live_d.blink[idx_d] && blink_d[BLINK_DIV-1])) begin
                seg_hi = SEG_OFF;
            end else if (live_d.raw_mode) begin
                seg_hi = live_d.raw[{idx_d, 3'b000} +: 8];
            end else begin
                seg_hi = {live_d.point[idx_d], dec_seg};
            end
        end
        an_d  = (ACTIVE_LOW != 0) ? ~an_hi  : an_hi;
        seg_d = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            psc_q     <= '0;
            blink_q   <= '0;
            idx_q     <= '0;
            run_q     <= 1'b0;
            pending_q <= 1'b0;
            shadow_q  <= '0;
            live_q    <= '0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_IDLE;
            frame_q   <= 1'b0;
        end else begin
            psc_q     <= psc_d;
            blink_q   <= blink_d;
            idx_q     <= idx_d;
            run_q     <= run_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            live_q    <= live_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.an_o    = an_q;
    assign bus.seg_o   = seg_q;
    assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_nch.sv
// Bench for seg7_scan_nch (4 digits, 4-cycle slots, 16-cycle blink, active-low pins).
module tb_seg7_scan_nch;

    localparam logic [6:0] HEX7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    localparam logic [3:0] AN_EXP [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    typedef struct packed {
        logic        rm;
        logic [15:0] hex;
        logic [31:0] raw;
        logic [3:0]  pt;
        logic [3:0]  bl;
        logic [3:0]  bk;
    } set_t;

    typedef struct packed {
        set_t           in;
        logic [3:0][7:0] s;
    } vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fr;
    } exp_t;

    logic clk;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    seg7_scan_nch_if #(.DIGITS(4)) bus ();

    seg7_scan_nch #(.DIGITS(4), .SCAN_DIV(2), .BLINK_DIV(4), .ACTIVE_LOW(1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, advanced at each active edge.
    int   m_psc = 0, m_idx = 0, m_blink = 0;
    bit   m_run = 0, m_pend = 0, m_tick, m_wrap;
    set_t m_shadow = '0, m_live = '0, m_cur;
    exp_t m_exp, sb_e;
    exp_t sb_q [$];

    function automatic logic [7:0] exp_seg(input set_t s, input int d, input bit ph);
        logic [7:0] v;
        if (s.bl[d] || (s.bk[d] && ph)) v = 8'h00;
        else if (s.rm)                  v = s.raw[d*8 +: 8];
        else                            v = {s.pt[d], HEX7[s.hex[d*4 +: 4]]};
        return ~v;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_psc = 0; m_idx = 0; m_blink = 0; m_run = 0; m_pend = 0;
            m_shadow = '0; m_live = '0;
            sb_q.delete();
        end else begin
            m_cur  = '{rm: bus.raw_mode_in, hex: bus.hex_in, raw: bus.raw_in,
                       pt: bus.point_in, bl: bus.blank_in, bk: bus.blink_in};
            m_tick = (m_psc == 3);
            m_wrap = m_tick && m_run && (m_idx == 3);
            if (m_tick && m_run) m_idx = (m_idx + 1) % 4;
            if (m_tick) m_run = 1;
            if (m_wrap && (m_pend || bus.we)) m_live = bus.we ? m_cur : m_shadow;
            if (bus.we) m_shadow = m_cur;
            if (m_wrap) m_pend = 0;
            else if (bus.we) m_pend = 1;
            m_psc   = (m_psc + 1) % 4;
            m_blink = (m_blink + 1) % 16;
            m_exp.an  = m_run ? ~(4'b0001 << m_idx) : 4'hF;
            m_exp.seg = m_run ? exp_seg(m_live, m_idx, m_blink >= 8) : 8'hFF;
            m_exp.fr  = m_wrap;
            sb_q.push_back(m_exp);
        end
    end

    // Every sample compared against the model, or against all-off while in reset.
    always @(negedge clk) begin
        if (!rstn) begin
            checks++;
            if (bus.an_o !== 4'hF || bus.seg_o !== 8'hFF || bus.frame_o !== 1'b0) begin
                errors++;
                $display("FAIL sb_reset an=%h seg=%h fr=%b want an=f seg=ff fr=0",
                         bus.an_o, bus.seg_o, bus.frame_o);
            end
        end else if (sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            checks++;
            if (bus.an_o !== sb_e.an || bus.seg_o !== sb_e.seg || bus.frame_o !== sb_e.fr) begin
                errors++;
                $display("FAIL sb t=%0t an=%h seg=%h fr=%b want an=%h seg=%h fr=%b", $time,
                         bus.an_o, bus.seg_o, bus.frame_o, sb_e.an, sb_e.seg, sb_e.fr);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input set_t s, input logic we);
        bus.raw_mode_in = s.rm;
        bus.hex_in      = s.hex;
        bus.raw_in      = s.raw;
        bus.point_in    = s.pt;
        bus.blank_in    = s.bl;
        bus.blink_in    = s.bk;
        bus.we          = we;
    endtask

    task automatic load(input set_t s);
        @(negedge clk);
        drive(s, 1'b1);
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic wait_frame(input string nm);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.frame_o === 1'b1) found = 1;
            else @(negedge clk);
        end
        if (!found) chk({nm, "_timeout"}, 32'(bus.frame_o), 32'd1);
    endtask

    task automatic wait_an(input logic [3:0] v, input string nm);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.an_o === v) found = 1;
        end
        if (!found) chk({nm, "_timeout"}, 32'(bus.an_o), 32'(v));
    endtask

    vec_t vecs [8];
    set_t s;
    int   gap;

    initial begin
        vecs[0] = '{'{1'b0, 16'h3210, 32'h0, 4'b0001, 4'b0000, 4'b0000}, {8'hB0, 8'hA4, 8'hF9, 8'h40}};
        vecs[1] = '{'{1'b0, 16'hFFFF, 32'h0, 4'b0000, 4'b0000, 4'b0000}, {8'h8E, 8'h8E, 8'h8E, 8'h8E}};
        vecs[2] = '{'{1'b0, 16'hBA98, 32'h0, 4'b0000, 4'b0000, 4'b0000}, {8'h83, 8'h88, 8'h90, 8'h80}};
        vecs[3] = '{'{1'b0, 16'hEDC7, 32'h0, 4'b1010, 4'b0000, 4'b0000}, {8'h06, 8'hA1, 8'h46, 8'hF8}};
        vecs[4] = '{'{1'b0, 16'h3210, 32'h0, 4'b0000, 4'b0100, 4'b0000}, {8'hB0, 8'hFF, 8'hF9, 8'hC0}};
        vecs[5] = '{'{1'b1, 16'h1234, 32'h5AFF0081, 4'b1111, 4'b0000, 4'b0000}, {8'hA5, 8'h00, 8'hFF, 8'h7E}};
        vecs[6] = '{'{1'b0, 16'h4444, 32'h0, 4'b0000, 4'b0000, 4'b1111}, {8'h99, 8'hFF, 8'hFF, 8'h99}};
        vecs[7] = '{'{1'b0, 16'h5656, 32'h0, 4'b0000, 4'b1000, 4'b0001}, {8'hFF, 8'h82, 8'h92, 8'h82}};

        rstn = 1'b1;
        drive('0, 1'b0);
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_an", 32'(bus.an_o), 32'hF);
        chk("reset_seg", 32'(bus.seg_o), 32'hFF);

        // Release: dark for the first slot, digit 0 after the first tick.
        #2 rstn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("release_an%0d", i), 32'(bus.an_o), (i < 4) ? 32'hF : 32'hE);
        end
        chk("release_seg", 32'(bus.seg_o), 32'hC0);

        foreach (vecs[v]) begin
            load(vecs[v].in);
            wait_frame($sformatf("vec%0d_frame", v));
            for (int d = 0; d < 4; d++) begin
                if (d > 0) repeat (4) @(negedge clk);
                chk($sformatf("vec%0d_an%0d", v, d), 32'(bus.an_o), 32'(AN_EXP[d]));
                chk($sformatf("vec%0d_seg%0d", v, d), 32'(bus.seg_o), 32'(vecs[v].s[d]));
            end
        end

        // Frame pulse period.
        @(negedge clk);
        wait_frame("period_a");
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (bus.frame_o !== 1'b1 && gap < 40);
        chk("frame_period", 32'(gap), 32'd16);

        // Tear-free: load during digit 1; digits 2/3 keep old data this frame.
        s = vecs[0].in;
        load(s);
        @(negedge clk);
        wait_frame("tear_base");
        wait_an(4'hD, "tear_d1");
        s.hex = 16'hFFFF; s.pt = 4'b0000;
        drive(s, 1'b1);
        @(negedge clk);
        bus.we = 1'b0;
        wait_an(4'hB, "tear_d2");
        chk("tear_old_d2", 32'(bus.seg_o), 32'hA4);
        wait_an(4'h7, "tear_d3");
        chk("tear_old_d3", 32'(bus.seg_o), 32'hB0);
        wait_an(4'hE, "tear_d0");
        chk("tear_new_d0", 32'(bus.seg_o), 32'h8E);
        chk("tear_new_frame", 32'(bus.frame_o), 32'd1);
        wait_an(4'hD, "tear_d1b");
        chk("tear_new_d1", 32'(bus.seg_o), 32'h8E);

        // Load on the wrap tick goes live on the very next digit 0.
        wait_an(4'h7, "simul_d3");
        repeat (3) @(negedge clk);
        s.hex = 16'h5555;
        drive(s, 1'b1);
        @(negedge clk);
        bus.we = 1'b0;
        chk("simul_frame", 32'(bus.frame_o), 32'd1);
        chk("simul_an", 32'(bus.an_o), 32'hE);
        chk("simul_seg", 32'(bus.seg_o), 32'h92);
        chk("simul_pending", 32'(dut.pending_q), 32'd0);
        repeat (4) @(negedge clk);
        chk("simul_d1_seg", 32'(bus.seg_o), 32'h92);

        // Reset during digit 3 with a load pending: dark at once, load discarded.
        wait_an(4'h7, "rst_d3");
        s.hex = 16'h9999;
        drive(s, 1'b1);
        @(negedge clk);
        bus.we = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_an_now", 32'(bus.an_o), 32'hF);
        chk("rst_seg_now", 32'(bus.seg_o), 32'hFF);
        chk("rst_frame_now", 32'(bus.frame_o), 32'd0);
        @(negedge clk);
        #2 rstn = 1'b1;
        wait_an(4'hE, "rst_d0");
        chk("rst_zero_d0", 32'(bus.seg_o), 32'hC0);
        repeat (4) @(negedge clk);
        chk("rst_zero_an1", 32'(bus.an_o), 32'hD);
        chk("rst_zero_d1", 32'(bus.seg_o), 32'hC0);

        repeat (8) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
